// File: rtl/cache_miss_controller.sv
// Miss sequencer between a CPU block port, a direct-mapped cache and a line-wide memory.
// Write-through / write-allocate; define CACHE_CTRL_STATS_EN to add hit/miss counters.
module cache_miss_controller #(
  parameter int unsigned BLOCK_SIZE             = 4,
  parameter int unsigned NUM_OF_BLOCKS_PER_LINE = 2,
  parameter int unsigned NUM_OF_CACHE_LINES     = 4,
  parameter int unsigned ADDRESS_SIZE           = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         cpu_req,
  input  logic                                         cpu_we,
  input  logic [ADDRESS_SIZE-1:0]                      cpu_addr,
  input  logic [BLOCK_SIZE-1:0]                        cpu_wdata,
  output logic [BLOCK_SIZE-1:0]                        cpu_rdata,
  output logic                                         cpu_done,
  output logic                                         cpu_err,
  output logic                                         read,
  output logic                                         write,
  output logic                                         write_line,
  output logic [ADDRESS_SIZE-1:0]                      address,
  output logic [BLOCK_SIZE-1:0]                        data_i,
  output logic [BLOCK_SIZE*NUM_OF_BLOCKS_PER_LINE-1:0] line_i,
  input  logic [BLOCK_SIZE-1:0]                        data_o,
  input  logic                                         hit,
  input  logic                                         miss,
  output logic                                         mem_req,
  output logic                                         mem_we,
  output logic [ADDRESS_SIZE-1:0]                      mem_addr,
  output logic [BLOCK_SIZE-1:0]                        mem_wdata,
  input  logic [BLOCK_SIZE*NUM_OF_BLOCKS_PER_LINE-1:0] mem_rdata,
`ifdef CACHE_CTRL_STATS_EN
  output logic [15:0]                                  hit_count,
  output logic [15:0]                                  miss_count,
`endif
  input  logic                                         mem_ack
);

  localparam int unsigned BoffW = $clog2(NUM_OF_BLOCKS_PER_LINE);
  // Clears the block-offset bits so refills fetch the whole line.
  localparam logic [ADDRESS_SIZE-1:0] LineMask = ~ADDRESS_SIZE'((64'd1 << BoffW) - 64'd1);

  if (NUM_OF_CACHE_LINES == 0) begin : g_bad_cfg
    $error("NUM_OF_CACHE_LINES must be non-zero");
  end

  typedef enum logic [2:0] {
    StIdle, StLookup, StCheck, StRefill, StFill, StWthru, StDone
  } state_e;

  state_e                    state;
  logic                      op_we;
  logic [ADDRESS_SIZE-1:0]   op_addr;
  logic [BLOCK_SIZE-1:0]     op_wdata;
  logic                      retry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      op_we     <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      retry     <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      line_i    <= '0;
`ifdef CACHE_CTRL_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (cpu_req) begin
            op_we    <= cpu_we;
            op_addr  <= cpu_addr;
            op_wdata <= cpu_wdata;
            retry    <= 1'b0;
            state    <= StLookup;
          end
        end
        StLookup: state <= StCheck;
        StCheck: begin
          // Miss wins when the cache reports both.
          if (miss) begin
            if (retry) begin
              cpu_err <= 1'b1;
              state   <= StDone;
            end else begin
              state <= StRefill;
            end
          end else if (hit) begin
            if (!op_we) cpu_rdata <= data_o;
            state <= op_we ? StWthru : StDone;
          end
        end
        StRefill: begin
          if (mem_ack) begin
            line_i <= mem_rdata;
            state  <= StFill;
          end
        end
        StFill: begin
          retry <= 1'b1;
          state <= StLookup;
        end
        StWthru: if (mem_ack) state <= StDone;
        StDone: begin
          cpu_err <= 1'b0;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
`ifdef CACHE_CTRL_STATS_EN
      if (state == StCheck) begin
        if (miss) begin
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end else if (hit) begin
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end
      end
`endif
    end
  end

  assign read       = (state == StLookup) && !op_we;
  assign write      = (state == StLookup) && op_we;
  assign write_line = (state == StFill);
  assign mem_req    = (state == StRefill) || (state == StWthru);
  assign mem_we     = (state == StWthru);
  assign cpu_done   = (state == StDone);
  assign address    = op_addr;
  assign data_i     = op_wdata;
  assign mem_wdata  = op_wdata;
  assign mem_addr   = mem_we ? op_addr : (op_addr & LineMask);

endmodule
